frame_merge_delivery: RTL

FRAME_MERGE_DELIVERY -- requirements
Module: frame_merge_delivery

---
 rtl/frame_merge_pkg.sv | 35 +++
 rtl/frame_merge_delivery_rr_arbiter.sv | 36 +++
 rtl/frame_merge_delivery.sv | 135 +++++++++++++
 3 files changed

// File: rtl/frame_merge_pkg.sv
// ============================================================================
// frame_merge_pkg : shared state encoding and default constants for frame_merge_delivery
// Rev 1.0 -- optional TAG state present only when CHANNEL_TAG_EN is defined
// ============================================================================
`default_nettype none

package frame_merge_pkg;

`ifdef CHANNEL_TAG_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TAG   = 2'd1,
        XFER  = 2'd2,
        ABORT = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd2,
        ABORT = 2'd3
    } state_t;
`endif

    localparam logic [15:0] DEF_TAIL_MAGIC = 16'hEEEE;
    localparam logic [31:0] DEF_ABORT_WORD = 32'hDEADBEEF;
    localparam logic [15:0] TAG_PREFIX     = 16'hC0DE;

    // Channel index width, kept at least 1 bit for the single-channel build
    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/frame_merge_delivery_rr_arbiter.sv
// ============================================================================
// rr_arbiter : round-robin request picker, searching upward from last_grant+1
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
    import frame_merge_pkg::*;
#(
    parameter  int ADC_CHANEL = 4,
    localparam int CH_W       = chan_w(ADC_CHANEL)
) (
    input  logic [ADC_CHANEL-1:0] req,
    input  logic [CH_W-1:0]       last_grant,
    output logic [CH_W-1:0]       grant_idx,
    output logic                  grant_vld
);

    logic [CH_W-1:0] idx;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = last_grant;
        for (int i = 0; i < ADC_CHANEL; i++) begin
            idx = (idx == CH_W'(ADC_CHANEL - 1)) ? '0 : idx + CH_W'(1);
            if (!grant_vld && req[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/frame_merge_delivery.sv
// ============================================================================
// frame_merge_delivery : merges per-channel FWFT FIFO frames into one stream
// Rev 1.0 -- define CHANNEL_TAG_EN to prefix each frame with a channel tag word
// ============================================================================
`default_nettype none

module frame_merge_delivery
    import frame_merge_pkg::*;
#(
    parameter int                ADC_CHANEL      = 4,
    parameter int                DATA_W          = 32,
    parameter int                MAX_FRAME_WORDS = 1024,
    parameter logic [15:0]       TAIL_MAGIC      = DEF_TAIL_MAGIC,
    parameter logic [DATA_W-1:0] ABORT_WORD      = DATA_W'(DEF_ABORT_WORD)
) (
    input  logic                         clk_100m,
    input  logic                         reset_n,
    input  logic [ADC_CHANEL-1:0]        ch_en,
    input  logic [ADC_CHANEL-1:0]        fifo_empty,
    input  logic [ADC_CHANEL*DATA_W-1:0] data_in,
    output logic [ADC_CHANEL-1:0]        fifo_rden,
    input  logic                         dst_full,
    output logic                         fifo_wren,
    output logic [DATA_W-1:0]            data_out,
    output logic [3:0]                   cur_chan,
    output logic                         busy,
    output logic [31:0]                  frame_cnt,
    output logic [15:0]                  abort_cnt
);

    localparam int CH_W = chan_w(ADC_CHANEL);
    localparam int WC_W = $clog2(MAX_FRAME_WORDS + 1);

    state_t            state;
    logic [CH_W-1:0]   cur_idx;
    logic [CH_W-1:0]   last_grant;
    logic [CH_W-1:0]   grant_idx;
    logic              grant_vld;
    logic [WC_W-1:0]   word_cnt;
    logic [WC_W-1:0]   word_cnt_inc;
    logic [DATA_W-1:0] cur_word;
    logic              rd_ok;
    logic              is_tail;

    rr_arbiter #(
        .ADC_CHANEL (ADC_CHANEL)
    ) u_arb (
        .req        (ch_en & ~fifo_empty),
        .last_grant (last_grant),
        .grant_idx  (grant_idx),
        .grant_vld  (grant_vld)
    );

    assign cur_chan     = 4'(cur_idx);
    assign busy         = (state != IDLE);
    assign cur_word     = data_in[int'(cur_idx)*DATA_W +: DATA_W];
    assign is_tail      = (cur_word[DATA_W-1 -: 16] == TAIL_MAGIC);
    assign word_cnt_inc = word_cnt + WC_W'(1);
    assign rd_ok        = (state == XFER) && !fifo_empty[cur_idx] && !dst_full;

    // Read strobe must be combinational so the FWFT head is consumed in the same cycle
    always_comb begin
        fifo_rden = '0;
        if (rd_ok) begin
            fifo_rden[cur_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_100m or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cur_idx    <= '0;
            last_grant <= CH_W'(ADC_CHANEL - 1);
            word_cnt   <= '0;
            fifo_wren  <= 1'b0;
            data_out   <= '0;
            frame_cnt  <= '0;
            abort_cnt  <= '0;
        end else begin
            fifo_wren <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        cur_idx  <= grant_idx;
                        word_cnt <= '0;
`ifdef CHANNEL_TAG_EN
                        state    <= TAG;
`else
                        state    <= XFER;
`endif
                    end
                end
`ifdef CHANNEL_TAG_EN
                TAG: begin
                    if (!dst_full) begin
                        data_out  <= DATA_W'({TAG_PREFIX, 12'h000, cur_chan});
                        fifo_wren <= 1'b1;
                        state     <= XFER;
                    end
                end
`endif
                XFER: begin
                    if (rd_ok) begin
                        data_out  <= cur_word;
                        fifo_wren <= 1'b1;
                        word_cnt  <= word_cnt_inc;
                        // A tail on the limit word still closes the frame normally
                        if (is_tail) begin
                            state      <= IDLE;
                            last_grant <= cur_idx;
                            frame_cnt  <= frame_cnt + 32'd1;
                        end else if (word_cnt_inc == WC_W'(MAX_FRAME_WORDS)) begin
                            state <= ABORT;
                        end
                    end
                end
                ABORT: begin
                    if (!dst_full) begin
                        data_out   <= ABORT_WORD;
                        fifo_wren  <= 1'b1;
                        last_grant <= cur_idx;
                        state      <= IDLE;
                        if (abort_cnt != 16'hFFFF) begin
                            abort_cnt <= abort_cnt + 16'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
